// File: rtl/conv_shift_register_if.sv
// conv_shift_register bus: serial word in, serial word out
// and every stage exposed as a flat parallel tap bus.
interface conv_shift_register_if #(
  parameter int SIZE       = 5,
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]      shift_in;
  logic [DATA_WIDTH-1:0]      shift_out;
  logic [SIZE*DATA_WIDTH-1:0] data_out;

  modport master (
    output shift_in,
    input  shift_out,
    input  data_out
  );

  modport slave (
    input  shift_in,
    output shift_out,
    output data_out
  );
endinterface

// File: rtl/conv_shift_register.sv
// Fixed-depth tap/line buffer for the convolver datapath.
// Shifts one word per clock; stage 0 is the newest word.
module conv_shift_register #(
  parameter int SIZE       = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  r_reset,
  conv_shift_register_if.slave  bus
);

  logic [DATA_WIDTH-1:0] stage_q [SIZE];
  logic [DATA_WIDTH-1:0] stage_d [SIZE];

  // next state: new word into stage 0, every other stage moves one deeper
  always_comb begin
    for (int k = 0; k < SIZE; k++) begin
      stage_d[k] = '0;
    end
    stage_d[0] = bus.shift_in;
    for (int k = 1; k < SIZE; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // stage registers, cleared immediately when r_reset drops
  always_ff @(posedge clock or negedge r_reset) begin
    if (!r_reset) begin
      for (int k = 0; k < SIZE; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SIZE; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_tap
    assign bus.data_out[g*DATA_WIDTH +: DATA_WIDTH] = stage_q[g];
  end

  assign bus.shift_out = stage_q[SIZE-1];

endmodule

// File: tb/tb_conv_shift_register.sv
// Randomized self-checking bench for conv_shift_register
// against a queue-based reference of the last SIZE words.
module tb_conv_shift_register;

  localparam int SIZE = 5;
  localparam int DW   = 16;

  logic clock   = 1'b0;
  logic r_reset = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q [$];

  conv_shift_register_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) bus ();
  conv_shift_register_if #(.SIZE(1), .DATA_WIDTH(8)) sbus ();

  conv_shift_register #(
    .SIZE(SIZE),
    .DATA_WIDTH(DW)
  ) dut (
    .clock   (clock),
    .r_reset (r_reset),
    .bus     (bus)
  );

  conv_shift_register #(
    .SIZE(1),
    .DATA_WIDTH(8)
  ) dut1 (
    .clock   (clock),
    .r_reset (r_reset),
    .bus     (sbus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [79:0] obs,
                     input logic [79:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] exp_data();
    logic [79:0] e;
    e = '0;
    for (int i = 0; i < q.size(); i++) begin
      e[i*DW +: DW] = q[i];
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] exp_sout();
    if (q.size() == SIZE) return q[SIZE-1];
    return '0;
  endfunction

  task automatic step(input logic [DW-1:0] w);
    bus.shift_in = w;
    @(posedge clock);
    q.push_front(w);
    if (q.size() > SIZE) void'(q.pop_back());
    @(negedge clock);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_data"}, bus.data_out, exp_data());
    chk({tag, "_sout"}, {64'd0, bus.shift_out}, {64'd0, exp_sout()});
  endtask

  initial begin
    logic [DW-1:0] w;
    bus.shift_in  = '0;
    sbus.shift_in = '0;

    // reset state with clock edges during reset
    bus.shift_in = 16'hBEEF;
    repeat (2) @(negedge clock);
    chk("rst_data", bus.data_out, '0);
    chk("rst_sout", {64'd0, bus.shift_out}, '0);
    chk("rst_s1", {72'd0, sbus.data_out}, '0);
    r_reset = 1'b1;

    // single load
    step(16'h3524);
    chk("load_data", bus.data_out, 80'h3524);
    chk("load_sout", {64'd0, bus.shift_out}, '0);

    // async reset mid-stream
    step(16'h1111);
    #2 r_reset = 1'b0;
    #1;
    chk("async1_data", bus.data_out, '0);
    chk("async1_sout", {64'd0, bus.shift_out}, '0);
    q.delete();
    @(negedge clock);
    r_reset = 1'b1;

    // propagation
    for (int i = 1; i <= 5; i++) begin
      step(DW'(i));
      chk_all($sformatf("prop%0d", i));
    end
    chk("prop_full", bus.data_out,
        {16'h1, 16'h2, 16'h3, 16'h4, 16'h5});
    chk("prop_sout", {64'd0, bus.shift_out}, 80'h1);

    // overflow
    step(16'h0006);
    chk("ovf_sout", {64'd0, bus.shift_out}, 80'h2);
    chk("ovf_s0", {64'd0, bus.data_out[15:0]}, 80'h6);
    chk_all("ovf");

    // random stream
    for (int i = 0; i < 10; i++) begin
      w = DW'($urandom);
      step(w);
      chk($sformatf("rnd%0d_s0", i),
          {64'd0, bus.data_out[15:0]}, {64'd0, w});
      chk_all($sformatf("rnd%0d", i));
    end

    // async reset while clock keeps running
    bus.shift_in = 16'hA5A5;
    #2 r_reset = 1'b0;
    #1;
    chk("async2_data", bus.data_out, '0);
    chk("async2_sout", {64'd0, bus.shift_out}, '0);
    @(posedge clock);
    #1;
    chk("hold_data", bus.data_out, '0);
    q.delete();
    @(negedge clock);
    r_reset = 1'b1;

    // SIZE=1 corner alongside a fresh fill
    sbus.shift_in = 8'hA5;
    step(16'h7E57);
    chk("s1_sout", {72'd0, sbus.shift_out}, 80'hA5);
    chk("s1_data", {72'd0, sbus.data_out}, 80'hA5);
    chk_all("refill");
    sbus.shift_in = 8'h3C;
    step(16'h0F0F);
    chk("s1_next", {72'd0, sbus.shift_out}, 80'h3C);
    chk_all("refill2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
